// File: rtl/memory_bus_write_decoder_pkg.sv
// Shared encodings for the CPU memory-bus write decoder: BRAM selects, snooped
// register addresses, FSM states and the registered bus sample.
package memory_bus_write_decoder_pkg;

  localparam int BUS_ADDR_W = 14;
  localparam int BUS_DATA_W = 16;
  localparam int SEL_W      = 2;

  localparam int MOD_SEG_W   = 1;
  localparam int STM_SEG_W   = 1;
  localparam int STM_PAGE_W  = 4;
  localparam int DUTY_PAGE_W = 1;
  localparam int WR_COUNT_W  = 16;

  localparam logic [SEL_W-1:0] BRAM_SELECT_CONTROLLER  = 2'd0;
  localparam logic [SEL_W-1:0] BRAM_SELECT_MOD         = 2'd1;
  localparam logic [SEL_W-1:0] BRAM_SELECT_DUTY_TABLE  = 2'd2;
  localparam logic [SEL_W-1:0] BRAM_SELECT_STM         = 2'd3;

  // Controller-space registers that steer the upper address bits of the other BRAMs
  localparam logic [BUS_ADDR_W-1:0] ADDR_MOD_MEM_WR_SEGMENT                = 14'h0020;
  localparam logic [BUS_ADDR_W-1:0] ADDR_STM_MEM_WR_SEGMENT                = 14'h0021;
  localparam logic [BUS_ADDR_W-1:0] ADDR_STM_MEM_WR_PAGE                   = 14'h0022;
  localparam logic [BUS_ADDR_W-1:0] ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE = 14'h0023;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_HOLD   = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [SEL_W-1:0]      sel;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/memory_bus_write_decoder_if.sv
// CPU-side memory bus level signals as seen by the write decoder.
interface memory_bus_write_decoder_if;
  import memory_bus_write_decoder_pkg::*;

  logic                  EN;
  logic                  WE;
  logic [SEL_W-1:0]      BRAM_SELECT;
  logic [BUS_ADDR_W-1:0] BRAM_ADDR;
  logic [BUS_DATA_W-1:0] DATA_IN;

  modport master (output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN);
  modport slave  (input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN);
endinterface

// File: rtl/memory_bus_page_shadow.sv
// Snoops committed controller writes and keeps the segment/page shadows that
// extend MOD, DUTY and STM write addresses.
module memory_bus_page_shadow
  import memory_bus_write_decoder_pkg::*;
#(
  parameter int STM_PAGE_WIDTH  = STM_PAGE_W,
  parameter int DUTY_PAGE_WIDTH = DUTY_PAGE_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cnt_commit_i,
  input  logic [BUS_ADDR_W-1:0]      addr_i,
  input  logic [BUS_DATA_W-1:0]      data_i,
  output logic [MOD_SEG_W-1:0]       mod_segment_o,
  output logic [STM_SEG_W-1:0]       stm_segment_o,
  output logic [STM_PAGE_WIDTH-1:0]  stm_page_o,
  output logic [DUTY_PAGE_WIDTH-1:0] duty_page_o
);

  logic [MOD_SEG_W-1:0]       mod_seg_q,   mod_seg_d;
  logic [STM_SEG_W-1:0]       stm_seg_q,   stm_seg_d;
  logic [STM_PAGE_WIDTH-1:0]  stm_page_q,  stm_page_d;
  logic [DUTY_PAGE_WIDTH-1:0] duty_page_q, duty_page_d;

  always_comb begin
    mod_seg_d   = mod_seg_q;
    stm_seg_d   = stm_seg_q;
    stm_page_d  = stm_page_q;
    duty_page_d = duty_page_q;
    if (cnt_commit_i) begin
      case (addr_i)
        ADDR_MOD_MEM_WR_SEGMENT:                mod_seg_d   = data_i[MOD_SEG_W-1:0];
        ADDR_STM_MEM_WR_SEGMENT:                stm_seg_d   = data_i[STM_SEG_W-1:0];
        ADDR_STM_MEM_WR_PAGE:                   stm_page_d  = data_i[STM_PAGE_WIDTH-1:0];
        ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE: duty_page_d = data_i[DUTY_PAGE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mod_seg_q   <= '0;
      stm_seg_q   <= '0;
      stm_page_q  <= '0;
      duty_page_q <= '0;
    end else begin
      mod_seg_q   <= mod_seg_d;
      stm_seg_q   <= stm_seg_d;
      stm_page_q  <= stm_page_d;
      duty_page_q <= duty_page_d;
    end
  end

  assign mod_segment_o = mod_seg_q;
  assign stm_segment_o = stm_seg_q;
  assign stm_page_o    = stm_page_q;
  assign duty_page_o   = duty_page_q;

endmodule

// File: rtl/memory_bus_write_decoder.sv
// Turns level-style CPU bus writes into one registered write strobe per
// transaction, routed to the controller, MOD, DUTY or STM BRAM.
module memory_bus_write_decoder
  import memory_bus_write_decoder_pkg::*;
#(
  parameter int STM_PAGE_WIDTH  = STM_PAGE_W,
  parameter int DUTY_PAGE_WIDTH = DUTY_PAGE_W,
  parameter int WR_COUNT_WIDTH  = WR_COUNT_W
) (
  input  logic                                  BUS_CLK,
  input  logic                                  RST,
  memory_bus_write_decoder_if.slave             bus,
  output logic                                  CNT_WE,
  output logic [BUS_ADDR_W-1:0]                 CNT_ADDR,
  output logic                                  MOD_WE,
  output logic [BUS_ADDR_W+MOD_SEG_W-1:0]       MOD_ADDR,
  output logic                                  DUTY_WE,
  output logic [BUS_ADDR_W+DUTY_PAGE_WIDTH-1:0] DUTY_ADDR,
  output logic                                  STM_WE,
  output logic [BUS_ADDR_W+STM_SEG_W+STM_PAGE_WIDTH-1:0] STM_ADDR,
  output logic [BUS_DATA_W-1:0]                 WR_DATA,
  output logic [WR_COUNT_WIDTH-1:0]             WR_COUNT
);

  localparam int MOD_AW  = BUS_ADDR_W + MOD_SEG_W;
  localparam int DUTY_AW = BUS_ADDR_W + DUTY_PAGE_WIDTH;
  localparam int STM_AW  = BUS_ADDR_W + STM_SEG_W + STM_PAGE_WIDTH;

  bus_req_t  s1_q;
  logic      rst_dly_q;
  wr_state_e state_q, state_d;
  logic      commit;
  logic      s1_wr;

  logic [3:0]                  we_q,        we_d;
  logic [BUS_ADDR_W-1:0]       cnt_addr_q,  cnt_addr_d;
  logic [MOD_AW-1:0]           mod_addr_q,  mod_addr_d;
  logic [DUTY_AW-1:0]          duty_addr_q, duty_addr_d;
  logic [STM_AW-1:0]           stm_addr_q,  stm_addr_d;
  logic [BUS_DATA_W-1:0]       data_q,      data_d;
  logic [WR_COUNT_WIDTH-1:0]   count_q,     count_d;

  logic [MOD_SEG_W-1:0]        mod_seg;
  logic [STM_SEG_W-1:0]        stm_seg;
  logic [STM_PAGE_WIDTH-1:0]   stm_page;
  logic [DUTY_PAGE_WIDTH-1:0]  duty_page;

  assign s1_wr = s1_q.en && s1_q.we;

  // COMMIT leaves straight to IDLE when the write already ended, so a single
  // low sample of WE between writes is enough to arm the next one. HOLD
  // ignores its exit for the first cycle out of reset so a write that was
  // active across reset is never taken.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE:   if (s1_wr) state_d = ST_COMMIT;
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = s1_wr ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD:   if (!rst_dly_q && !s1_wr) state_d = ST_IDLE;
      default:   state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    we_d        = '0;
    cnt_addr_d  = cnt_addr_q;
    mod_addr_d  = mod_addr_q;
    duty_addr_d = duty_addr_q;
    stm_addr_d  = stm_addr_q;
    data_d      = data_q;
    count_d     = count_q;
    if (commit) begin
      we_d[s1_q.sel] = 1'b1;
      data_d         = s1_q.data;
      count_d        = count_q + WR_COUNT_WIDTH'(1);
      case (s1_q.sel)
        BRAM_SELECT_CONTROLLER: cnt_addr_d  = s1_q.addr;
        BRAM_SELECT_MOD:        mod_addr_d  = {mod_seg, s1_q.addr};
        BRAM_SELECT_DUTY_TABLE: duty_addr_d = {duty_page, s1_q.addr};
        default:                stm_addr_d  = {stm_seg, stm_page, s1_q.addr};
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      s1_q        <= '0;
      rst_dly_q   <= 1'b1;
      state_q     <= ST_HOLD;
      we_q        <= '0;
      cnt_addr_q  <= '0;
      mod_addr_q  <= '0;
      duty_addr_q <= '0;
      stm_addr_q  <= '0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      s1_q        <= {bus.EN, bus.WE, bus.BRAM_SELECT, bus.BRAM_ADDR, bus.DATA_IN};
      rst_dly_q   <= 1'b0;
      state_q     <= state_d;
      we_q        <= we_d;
      cnt_addr_q  <= cnt_addr_d;
      mod_addr_q  <= mod_addr_d;
      duty_addr_q <= duty_addr_d;
      stm_addr_q  <= stm_addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end

  memory_bus_page_shadow #(
    .STM_PAGE_WIDTH (STM_PAGE_WIDTH),
    .DUTY_PAGE_WIDTH(DUTY_PAGE_WIDTH)
  ) u_shadow (
    .clk_i        (BUS_CLK),
    .rst_i        (RST),
    .cnt_commit_i (commit && (s1_q.sel == BRAM_SELECT_CONTROLLER)),
    .addr_i       (s1_q.addr),
    .data_i       (s1_q.data),
    .mod_segment_o(mod_seg),
    .stm_segment_o(stm_seg),
    .stm_page_o   (stm_page),
    .duty_page_o  (duty_page)
  );

  assign CNT_WE    = we_q[BRAM_SELECT_CONTROLLER];
  assign MOD_WE    = we_q[BRAM_SELECT_MOD];
  assign DUTY_WE   = we_q[BRAM_SELECT_DUTY_TABLE];
  assign STM_WE    = we_q[BRAM_SELECT_STM];
  assign CNT_ADDR  = cnt_addr_q;
  assign MOD_ADDR  = mod_addr_q;
  assign DUTY_ADDR = duty_addr_q;
  assign STM_ADDR  = stm_addr_q;
  assign WR_DATA   = data_q;
  assign WR_COUNT  = count_q;

endmodule

// File: tb/tb_memory_bus_write_decoder.sv
// Directed bench for memory_bus_write_decoder: transaction-level expectations
// queued by the driver and checked against the outputs every cycle.
module tb_memory_bus_write_decoder;
  import memory_bus_write_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_bus_write_decoder_if bus_if();

  logic        cnt_we, mod_we, duty_we, stm_we;
  logic [13:0] cnt_addr;
  logic [14:0] mod_addr, duty_addr;
  logic [18:0] stm_addr;
  logic [15:0] wr_data, wr_count;

  memory_bus_write_decoder dut (
    .BUS_CLK  (clk),
    .RST      (rst),
    .bus      (bus_if),
    .CNT_WE   (cnt_we),
    .CNT_ADDR (cnt_addr),
    .MOD_WE   (mod_we),
    .MOD_ADDR (mod_addr),
    .DUTY_WE  (duty_we),
    .DUTY_ADDR(duty_addr),
    .STM_WE   (stm_we),
    .STM_ADDR (stm_addr),
    .WR_DATA  (wr_data),
    .WR_COUNT (wr_count)
  );

  typedef struct {
    int          due;
    logic [1:0]  sel;
    logic [18:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          vectors = 0, miscompares = 0, cyc = 0, strobes = 0, s0;
  bit          mon_en = 1'b0;
  logic [18:0] m_addr[4];
  logic [15:0] m_data, m_cnt;
  logic        m_mseg, m_sseg, m_dpage;
  logic [3:0]  m_spage;
  logic [3:0]  got_we, exp_we;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_addr[i] = '0;
    m_data = '0; m_cnt = '0;
    m_mseg = 1'b0; m_sseg = 1'b0; m_dpage = 1'b0; m_spage = '0;
    q.delete();
  endtask

  // Expected transaction: full BRAM address from the shadows as they stand
  // now; a controller page write only changes them for later writes.
  task automatic push(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d);
    exp_t e;
    e.due  = cyc + 3;
    e.sel  = sel;
    e.data = d;
    case (sel)
      2'd0:    e.addr = {5'b0, a};
      2'd1:    e.addr = {4'b0, m_mseg, a};
      2'd2:    e.addr = {4'b0, m_dpage, a};
      default: e.addr = {m_sseg, m_spage, a};
    endcase
    q.push_back(e);
    if (sel == BRAM_SELECT_CONTROLLER) begin
      if (a == ADDR_MOD_MEM_WR_SEGMENT)                m_mseg  = d[0];
      if (a == ADDR_STM_MEM_WR_SEGMENT)                m_sseg  = d[0];
      if (a == ADDR_STM_MEM_WR_PAGE)                   m_spage = d[3:0];
      if (a == ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE) m_dpage = d[0];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [13:0] a, input logic [15:0] d, input int hold);
    tick(1);
    bus_if.EN = 1'b1; bus_if.WE = 1'b1;
    bus_if.BRAM_SELECT = sel; bus_if.BRAM_ADDR = a; bus_if.DATA_IN = d;
    push(sel, a, d);
    tick(hold);
    bus_if.WE = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      got_we = {stm_we, duty_we, mod_we, cnt_we};
      exp_we = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        cur = q.pop_front();
        exp_we[cur.sel] = 1'b1;
        m_addr[cur.sel] = cur.addr;
        m_data = cur.data;
        m_cnt  = m_cnt + 16'd1;
      end
      if (got_we != 4'd0) strobes++;
      chk("multi_we", 32'($countones(got_we) > 1), 32'd0);
      chk("we_vec", 32'(got_we), 32'(exp_we));
      chk("cnt_addr", 32'(cnt_addr), 32'(m_addr[0][13:0]));
      chk("mod_addr", 32'(mod_addr), 32'(m_addr[1][14:0]));
      chk("duty_addr", 32'(duty_addr), 32'(m_addr[2][14:0]));
      chk("stm_addr", 32'(stm_addr), 32'(m_addr[3]));
      chk("wr_data", 32'(wr_data), 32'(m_data));
      chk("wr_count", 32'(wr_count), 32'(m_cnt));
    end
  end

  initial begin
    bus_if.EN = 1'b0; bus_if.WE = 1'b0;
    bus_if.BRAM_SELECT = '0; bus_if.BRAM_ADDR = '0; bus_if.DATA_IN = '0;
    model_reset();
    tick(3);
    chk("rst_we", 32'({stm_we, duty_we, mod_we, cnt_we}), 32'd0);
    chk("rst_cnt_addr", 32'(cnt_addr), 32'd0);
    chk("rst_stm_addr", 32'(stm_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    rst = 1'b0; mon_en = 1'b1;
    tick(3);

    // controller write, WE high two cycles
    s0 = strobes;
    wr(BRAM_SELECT_CONTROLLER, 14'h0012, 16'hBEEF, 2);
    tick(4);
    chk("t1_cnt_addr", 32'(cnt_addr), 32'h0012);
    chk("t1_wr_data", 32'(wr_data), 32'hBEEF);
    chk("t1_wr_count", 32'(wr_count), 32'd1);
    chk("t1_strobes", 32'(strobes - s0), 32'd1);

    // STM segment/page snoop, then STM data write
    s0 = strobes;
    wr(BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_SEGMENT, 16'h0001, 1);
    wr(BRAM_SELECT_CONTROLLER, ADDR_STM_MEM_WR_PAGE, 16'h0003, 1);
    wr(BRAM_SELECT_STM, 14'h0105, 16'hA5A5, 1);
    tick(4);
    chk("stm_addr_lit", 32'(stm_addr), 32'h4C105);
    chk("stm_strobes", 32'(strobes - s0), 32'd3);

    wr(BRAM_SELECT_CONTROLLER, ADDR_MOD_MEM_WR_SEGMENT, 16'hFFFF, 1);
    wr(BRAM_SELECT_MOD, 14'h00AB, 16'h0F0F, 1);
    tick(4);
    chk("mod_addr_lit", 32'(mod_addr), 32'h40AB);

    // long WE, then back-to-back writes with one low cycle between
    s0 = strobes;
    wr(BRAM_SELECT_MOD, 14'h0200, 16'h1111, 10);
    tick(4);
    chk("long_we_strobes", 32'(strobes - s0), 32'd1);
    s0 = strobes;
    wr(BRAM_SELECT_CONTROLLER, 14'h0300, 16'h2222, 1);
    wr(BRAM_SELECT_DUTY_TABLE, 14'h0301, 16'h3333, 1);
    tick(4);
    chk("b2b_strobes", 32'(strobes - s0), 32'd2);

    // EN drops in the same cycle WE rises
    s0 = strobes;
    tick(1); bus_if.EN = 1'b0; bus_if.WE = 1'b1; bus_if.BRAM_ADDR = 14'h0444;
    tick(4); bus_if.WE = 1'b0;
    tick(1); bus_if.EN = 1'b1;
    tick(3);
    chk("en_drop_strobes", 32'(strobes - s0), 32'd0);
    chk("en_drop_count", 32'(wr_count), 32'(m_cnt));

    // reset with WE high, released with WE still high
    tick(1); bus_if.WE = 1'b1; bus_if.BRAM_SELECT = BRAM_SELECT_CONTROLLER;
    bus_if.BRAM_ADDR = 14'h0033; bus_if.DATA_IN = 16'h1234;
    tick(1); rst = 1'b1; mon_en = 1'b0; model_reset();
    tick(2);
    chk("mid_rst_we", 32'({stm_we, duty_we, mod_we, cnt_we}), 32'd0);
    chk("mid_rst_cnt_addr", 32'(cnt_addr), 32'd0);
    chk("mid_rst_mod_addr", 32'(mod_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
    rst = 1'b0; mon_en = 1'b1;
    s0 = strobes;
    tick(6);
    chk("post_rst_strobes", 32'(strobes - s0), 32'd0);
    bus_if.WE = 1'b0;
    wr(BRAM_SELECT_CONTROLLER, 14'h0033, 16'h1234, 1);
    tick(4);
    chk("post_rst_count", 32'(wr_count), 32'd1);

    // duty-table sweep across both pages
    s0 = strobes;
    wr(BRAM_SELECT_CONTROLLER, ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE, 16'h0000, 1);
    for (int i = 0; i < 32768; i++) begin
      wr(BRAM_SELECT_DUTY_TABLE, i[13:0], 16'(i) ^ 16'h5A5A, 1);
      if (i == 16383) begin
        tick(3);
        chk("duty_addr_lo", 32'(duty_addr), 32'h3FFF);
        wr(BRAM_SELECT_CONTROLLER, ADDR_PULSE_WIDTH_ENCODER_TABLE_WR_PAGE, 16'h0001, 1);
      end
    end
    tick(4);
    chk("duty_addr_hi", 32'(duty_addr), 32'h7FFF);
    chk("duty_strobes", 32'(strobes - s0), 32'd32770);

    tick(4);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
